// File: rtl/sw_pkg.sv
// Shared types and helpers for the Smith-Waterman sequence loader.
package sw_pkg;

  localparam int LEN_REF_DEF   = 64;
  localparam int LEN_QUERY_DEF = 48;

  typedef enum logic [2:0] {
    LOAD_REF,
    LOAD_Q,
    KICK,
    STREAM,
    WAIT,
    DONE
  } sw_state_t;

  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_G_UP = 8'h47;
  localparam logic [7:0] ASCII_T_UP = 8'h54;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_G_LO = 8'h67;
  localparam logic [7:0] ASCII_T_LO = 8'h74;

  typedef struct packed {
    logic [1:0] sym;
    logic       bad;
  } base_code_t;

  // Map one ASCII byte to a 2-bit base; unknown bytes become A and raise bad.
  function automatic base_code_t encode_base(input logic [7:0] ch);
    base_code_t r;
    r.sym = 2'd0;
    r.bad = 1'b0;
    case (ch)
      ASCII_A_UP, ASCII_A_LO: r.sym = 2'd0;
      ASCII_C_UP, ASCII_C_LO: r.sym = 2'd1;
      ASCII_G_UP, ASCII_G_LO: r.sym = 2'd2;
      ASCII_T_UP, ASCII_T_LO: r.sym = 2'd3;
      default:                r.bad = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sw_char_encoder.sv
// Registered ASCII to 2-bit nucleotide encoder; output valid follows the strobe by one cycle.
module sw_char_encoder
  import sw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic [7:0] ascii,
  output logic       sym_valid,
  output logic [1:0] sym,
  output logic       sym_bad
);

  base_code_t code;

  assign code = encode_base(ascii);

  // Capture the encoded symbol whenever a character is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_valid <= 1'b0;
      sym       <= 2'd0;
      sym_bad   <= 1'b0;
    end else begin
      sym_valid <= strobe;
      if (strobe) begin
        sym     <= code.sym;
        sym_bad <= code.bad;
      end
    end
  end

endmodule

// File: rtl/sw_seq_loader.sv
// Buffers one reference/query pair from the host, replays it into the SW core and returns the result.
module sw_seq_loader
  import sw_pkg::*;
#(
  parameter int LEN_REF         = LEN_REF_DEF,
  parameter int LEN_QUERY       = LEN_QUERY_DEF,
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int TIMEOUT         = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_char,
  output logic                       sw_rst,
  output logic                       sw_valid,
  output logic [1:0]                 sw_ref,
  output logic [1:0]                 sw_query,
  input  logic                       sw_finish,
  input  logic [WIDTH_SCORE-1:0]     sw_max,
  input  logic [WIDTH_POS_REF-1:0]   sw_pos_ref,
  input  logic [WIDTH_POS_QUERY-1:0] sw_pos_query,
  output logic                       out_valid,
  output logic [WIDTH_SCORE-1:0]     out_max,
  output logic [WIDTH_POS_REF-1:0]   out_pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] out_pos_query,
  output logic                       err_char,
  output logic                       err_timeout
);

  localparam int CW  = $clog2(LEN_REF + 1);
  localparam int RAW = (LEN_REF > 1) ? $clog2(LEN_REF) : 1;
  localparam int QAW = (LEN_QUERY > 1) ? $clog2(LEN_QUERY) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] REF_LAST = CW'(LEN_REF - 1);
  localparam logic [CW-1:0] QRY_LAST = CW'(LEN_QUERY - 1);
  localparam logic [CW-1:0] QRY_LEN  = CW'(LEN_QUERY);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);

  sw_state_t     state, state_nxt;
  logic [CW-1:0] wr_cnt, wr_cnt_nxt;
  logic [CW-1:0] rd_cnt, rd_cnt_nxt;
  logic [TW-1:0] wd_cnt, wd_cnt_nxt;
  logic          xfer;
  logic          finish_hit;
  logic          timeout_hit;

  logic          sym_valid;
  logic [1:0]    sym;
  logic          sym_bad;
  logic [CW-1:0] wr_addr_q;
  logic          wr_qry_q;

  logic [1:0]    ref_mem [LEN_REF];
  logic [1:0]    qry_mem [LEN_QUERY];
  logic [1:0]    qry_word;
  logic          stream_nxt;

  assign in_ready   = (state == LOAD_REF) || (state == LOAD_Q);
  assign xfer       = in_valid && in_ready;
  assign out_valid  = (state == DONE);
  assign stream_nxt = (state_nxt == STREAM);

  sw_char_encoder u_enc (
    .clk       (clk),
    .reset     (reset),
    .strobe    (xfer),
    .ascii     (in_char),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sym_bad   (sym_bad)
  );

  // Delay the write address and target buffer so they line up with the encoder output.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr_q <= '0;
      wr_qry_q  <= 1'b0;
    end else if (xfer) begin
      wr_addr_q <= wr_cnt;
      wr_qry_q  <= (state == LOAD_Q);
    end
  end

  // Symbol buffers; contents are simply overwritten by the next load, so no reset is needed.
  always_ff @(posedge clk) begin
    if (sym_valid) begin
      if (wr_qry_q) begin
        qry_mem[wr_addr_q[QAW-1:0]] <= sym;
      end else begin
        ref_mem[wr_addr_q[RAW-1:0]] <= sym;
      end
    end
  end

  // The last query symbol lands in the buffer during KICK, so forward it if it is read in the same cycle.
  always_comb begin
    qry_word = qry_mem[rd_cnt_nxt[QAW-1:0]];
    if (sym_valid && wr_qry_q && (wr_addr_q == rd_cnt_nxt)) begin
      qry_word = sym;
    end
  end

  // Next-state, counter and watchdog decisions for the load/kick/stream/wait sequence.
  always_comb begin
    state_nxt   = state;
    wr_cnt_nxt  = wr_cnt;
    rd_cnt_nxt  = rd_cnt;
    wd_cnt_nxt  = wd_cnt;
    finish_hit  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      LOAD_REF: begin
        if (xfer) begin
          if (wr_cnt == REF_LAST) begin
            wr_cnt_nxt = '0;
            state_nxt  = LOAD_Q;
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
          end
        end
      end
      LOAD_Q: begin
        if (xfer) begin
          if (wr_cnt == QRY_LAST) begin
            wr_cnt_nxt = '0;
            state_nxt  = KICK;
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
          end
        end
      end
      KICK: begin
        rd_cnt_nxt = '0;
        state_nxt  = STREAM;
      end
      STREAM: begin
        if (rd_cnt == REF_LAST) begin
          rd_cnt_nxt = '0;
          wd_cnt_nxt = '0;
          state_nxt  = WAIT;
        end else begin
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
      WAIT: begin
        if (sw_finish) begin
          finish_hit = 1'b1;
          state_nxt  = DONE;
        end else if (wd_cnt == WD_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end else begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      DONE: begin
        wd_cnt_nxt = '0;
        state_nxt  = LOAD_REF;
      end
      default: state_nxt = LOAD_REF;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD_REF;
      wr_cnt <= '0;
      rd_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wr_cnt <= wr_cnt_nxt;
      rd_cnt <= rd_cnt_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  // Core-facing outputs are registered from the next state so they align with KICK and STREAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_rst   <= 1'b0;
      sw_valid <= 1'b0;
      sw_ref   <= 2'd0;
      sw_query <= 2'd0;
    end else begin
      sw_rst   <= (state_nxt == KICK);
      sw_valid <= stream_nxt;
      sw_ref   <= stream_nxt ? ref_mem[rd_cnt_nxt[RAW-1:0]] : 2'd0;
      sw_query <= (stream_nxt && (rd_cnt_nxt < QRY_LEN)) ? qry_word : 2'd0;
    end
  end

  // Capture the core result, or zeros on a watchdog abort, and hold it until the next run.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_max       <= '0;
      out_pos_ref   <= '0;
      out_pos_query <= '0;
      err_timeout   <= 1'b0;
    end else if (finish_hit) begin
      out_max       <= sw_max;
      out_pos_ref   <= sw_pos_ref;
      out_pos_query <= sw_pos_query;
    end else if (timeout_hit) begin
      out_max       <= '0;
      out_pos_ref   <= '0;
      out_pos_query <= '0;
      err_timeout   <= 1'b1;
    end
  end

  // Sticky flag for any non-ACGT character that made it into a buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_char <= 1'b0;
    end else if (sym_valid && sym_bad) begin
      err_char <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sw_seq_loader.sv
// Scoreboard bench for sw_seq_loader: stimulus pushes expected stream/result entries, a monitor pops them.
module tb_sw_seq_loader;

  localparam int LR = 64;
  localparam int LQ = 48;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'h00;
  logic       sw_rst, sw_valid;
  logic [1:0] sw_ref, sw_query;
  logic       sw_finish = 1'b0;
  logic [7:0] sw_max = 8'h00;
  logic [6:0] sw_pos_ref = 7'h00;
  logic [5:0] sw_pos_query = 6'h00;
  logic       out_valid;
  logic [7:0] out_max;
  logic [6:0] out_pos_ref;
  logic [5:0] out_pos_query;
  logic       err_char, err_timeout;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] q;
  } stream_t;

  typedef struct packed {
    logic [7:0] mx;
    logic [6:0] pr;
    logic [5:0] pq;
    logic       ec;
    logic       et;
  } result_t;

  stream_t exp_stream[$];
  result_t exp_result[$];
  stream_t mon_s;
  result_t mon_r;

  int checks = 0;
  int errors = 0;

  logic [7:0] bases [4] = '{8'h41, 8'h43, 8'h47, 8'h54};
  logic [7:0] ref_str [LR];
  logic [7:0] qry_str [LQ];
  logic       exp_err_char = 1'b0;
  logic       exp_err_timeout = 1'b0;

  sw_seq_loader dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_char       (in_char),
    .sw_rst        (sw_rst),
    .sw_valid      (sw_valid),
    .sw_ref        (sw_ref),
    .sw_query      (sw_query),
    .sw_finish     (sw_finish),
    .sw_max        (sw_max),
    .sw_pos_ref    (sw_pos_ref),
    .sw_pos_query  (sw_pos_query),
    .out_valid     (out_valid),
    .out_max       (out_max),
    .out_pos_ref   (out_pos_ref),
    .out_pos_query (out_pos_query),
    .err_char      (err_char),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  // Reference encoding table: {bad, sym}.
  function automatic logic [2:0] model_encode(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: return 3'b000;
      8'h43, 8'h63: return 3'b001;
      8'h47, 8'h67: return 3'b010;
      8'h54, 8'h74: return 3'b011;
      default:      return 3'b100;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every streamed symbol and every result strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (sw_valid === 1'b1) begin
      if (exp_stream.size() == 0) begin
        check_output("stream_unexpected", 32'd1, 32'd0);
      end else begin
        mon_s = exp_stream.pop_front();
        check_output("stream_ref", {30'd0, sw_ref}, {30'd0, mon_s.r});
        check_output("stream_query", {30'd0, sw_query}, {30'd0, mon_s.q});
      end
    end
    if (out_valid === 1'b1) begin
      if (exp_result.size() == 0) begin
        check_output("result_unexpected", 32'd1, 32'd0);
      end else begin
        mon_r = exp_result.pop_front();
        check_output("out_max", {24'd0, out_max}, {24'd0, mon_r.mx});
        check_output("out_pos_ref", {25'd0, out_pos_ref}, {25'd0, mon_r.pr});
        check_output("out_pos_query", {26'd0, out_pos_query}, {26'd0, mon_r.pq});
        check_output("result_err_char", {31'd0, err_char}, {31'd0, mon_r.ec});
        check_output("result_err_timeout", {31'd0, err_timeout}, {31'd0, mon_r.et});
      end
    end
  end

  task automatic build_strings(input bit lower, input int bad_pos, input int shift);
    for (int k = 0; k < LR; k++) begin
      ref_str[k] = bases[k % 4] | (lower ? 8'h20 : 8'h00);
      if (k == bad_pos) ref_str[k] = 8'h4E;
    end
    for (int k = 0; k < LQ; k++) begin
      qry_str[k] = bases[(k + shift) % 4] | (lower ? 8'h20 : 8'h00);
    end
  endtask

  // Called and returns just after a rising edge; one character per transfer.
  task automatic send_char(input logic [7:0] c, input int stall);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_char  = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("ready_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic apply_stimulus(input int stall_max, input bit early, input bit respond,
                                input int reset_k, input logic [7:0] mx,
                                input logic [6:0] pr, input logic [5:0] pq);
    logic [2:0] cr, cq;
    stream_t    s;
    result_t    r;
    int         n, w;
    for (int k = 0; k < LR; k++) begin
      cr = model_encode(ref_str[k]);
      if (cr[2]) exp_err_char = 1'b1;
      send_char(ref_str[k], (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0);
    end
    for (int k = 0; k < LQ; k++) begin
      cq = model_encode(qry_str[k]);
      if (cq[2]) exp_err_char = 1'b1;
      send_char(qry_str[k], (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0);
    end
    for (int k = 0; k < LR; k++) begin
      cr  = model_encode(ref_str[k]);
      s.r = cr[1:0];
      s.q = 2'd0;
      if (k < LQ) begin
        cq  = model_encode(qry_str[k]);
        s.q = cq[1:0];
      end
      exp_stream.push_back(s);
    end
    // Cycle after the last query transfer is KICK.
    @(negedge clk);
    check_output("kick_rst", {31'd0, sw_rst}, 32'd1);
    check_output("kick_ready", {31'd0, in_ready}, 32'd0);
    n = 0;
    for (int i = 0; i < LR + 8; i++) begin
      @(negedge clk);
      if (sw_valid !== 1'b1) break;
      if (n == 0) check_output("rst_one_cycle", {31'd0, sw_rst}, 32'd0);
      if (early && n == 20) begin
        sw_finish = 1'b1; sw_max = 8'hEE; sw_pos_ref = 7'h55; sw_pos_query = 6'h2A;
      end
      if (early && n == 21) begin
        sw_finish = 1'b0; sw_max = 8'h00; sw_pos_ref = 7'h00; sw_pos_query = 6'h00;
      end
      if (n == reset_k) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("reset_drops_valid", {31'd0, sw_valid}, 32'd0);
        check_output("reset_ready", {31'd0, in_ready}, 32'd1);
        check_output("reset_no_kick", {31'd0, sw_rst}, 32'd0);
        exp_stream.delete();
        exp_err_char    = 1'b0;
        exp_err_timeout = 1'b0;
        @(posedge clk); #1;
        return;
      end
      n++;
    end
    check_output("stream_len", n, LR);
    if (respond) begin
      sw_finish = 1'b1; sw_max = mx; sw_pos_ref = pr; sw_pos_query = pq;
      r.mx = mx; r.pr = pr; r.pq = pq; r.ec = exp_err_char; r.et = exp_err_timeout;
      exp_result.push_back(r);
      @(negedge clk);
      sw_finish = 1'b0; sw_max = 8'h00; sw_pos_ref = 7'h00; sw_pos_query = 6'h00;
      check_output("done_strobe", {31'd0, out_valid}, 32'd1);
      check_output("done_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check_output("strobe_width", {31'd0, out_valid}, 32'd0);
      check_output("ready_back", {31'd0, in_ready}, 32'd1);
    end else begin
      exp_err_timeout = 1'b1;
      r.mx = 8'h00; r.pr = 7'h00; r.pq = 6'h00; r.ec = exp_err_char; r.et = 1'b1;
      exp_result.push_back(r);
      w = 0;
      for (int i = 0; i < 1100; i++) begin
        @(negedge clk);
        w++;
        if (out_valid === 1'b1) break;
      end
      check_output("timeout_cycles", w, 1023);
      @(negedge clk);
      check_output("timeout_ready_back", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_sw_rst", {31'd0, sw_rst}, 32'd0);
    check_output("rst_sw_valid", {31'd0, sw_valid}, 32'd0);
    check_output("rst_sw_ref", {30'd0, sw_ref}, 32'd0);
    check_output("rst_sw_query", {30'd0, sw_query}, 32'd0);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_out_max", {24'd0, out_max}, 32'd0);
    check_output("rst_out_pos_ref", {25'd0, out_pos_ref}, 32'd0);
    check_output("rst_out_pos_query", {26'd0, out_pos_query}, 32'd0);
    check_output("rst_err_char", {31'd0, err_char}, 32'd0);
    check_output("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    @(posedge clk); #1;

    $display("[TB] nominal pair");
    build_strings(1'b0, -1, 0);
    apply_stimulus(0, 1'b0, 1'b1, -1, 8'd96, 7'd48, 6'd48);

    $display("[TB] stalls and lowercase");
    build_strings(1'b1, -1, 2);
    apply_stimulus(3, 1'b0, 1'b1, -1, 8'd37, 7'd20, 6'd13);
    check_output("no_err_char", {31'd0, err_char}, 32'd0);

    $display("[TB] invalid character at reference position 10");
    build_strings(1'b0, 10, 1);
    apply_stimulus(0, 1'b0, 1'b1, -1, 8'd55, 7'd63, 6'd47);
    check_output("err_char_sticky", {31'd0, err_char}, 32'd1);

    $display("[TB] core never finishes");
    build_strings(1'b0, -1, 3);
    apply_stimulus(0, 1'b0, 1'b0, -1, 8'd0, 7'd0, 6'd0);
    check_output("err_timeout_set", {31'd0, err_timeout}, 32'd1);
    check_output("err_char_still", {31'd0, err_char}, 32'd1);

    $display("[TB] reset during stream");
    build_strings(1'b0, -1, 0);
    apply_stimulus(0, 1'b0, 1'b1, 30, 8'd0, 7'd0, 6'd0);
    check_output("reset_clears_err_char", {31'd0, err_char}, 32'd0);
    check_output("reset_clears_err_timeout", {31'd0, err_timeout}, 32'd0);
    build_strings(1'b1, -1, 1);
    apply_stimulus(1, 1'b0, 1'b1, -1, 8'd12, 7'd5, 6'd3);

    $display("[TB] early finish pulse during stream");
    build_strings(1'b0, -1, 2);
    apply_stimulus(0, 1'b1, 1'b1, -1, 8'd77, 7'd40, 6'd30);

    repeat (3) @(negedge clk);
    check_output("stream_queue_empty", exp_stream.size(), 0);
    check_output("result_queue_empty", exp_result.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no completion, expected completion");
    $fatal(1, "[TB] bench timed out");
  end

endmodule

// File: doc/sw_seq_loader.md
# sw_seq_loader

Upstream feeder for the Smith-Waterman core (`SW`). It accepts an ASCII nucleotide stream from the host over a valid/ready handshake and encodes it to 2-bit symbols. It buffers one reference/query pair, restarts the core, and replays the pair into the core's `valid`/`data_ref`/`data_query` inputs. It then waits for `finish` and returns the captured score and positions to the host as a one-cycle result pulse.

## Interface
- `LEN_REF`, 64, reference length (symbols)
- `LEN_QUERY`, 48, query length (symbols); must be ≤ `LEN_REF`
- `WIDTH_SCORE`, 8, width of core `max`
- `WIDTH_POS_REF`, 7, width of core `pos_ref`
- `WIDTH_POS_QUERY`, 6, width of core `pos_query`
- `TIMEOUT`, 1023, max WAIT cycles before abort
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  host character valid
- `in_ready`  out  1  loader can accept a character
- `in_char`  in  8  ASCII character
- `sw_rst`  out  1  reset pulse to core, drives core `reset`
- `sw_valid`  out  1  to core `valid`
- `sw_ref`  out  2  to core `data_ref`
- `sw_query`  out  2  to core `data_query`
- `sw_finish`  in  1  from core `finish`
- `sw_max` / `sw_pos_ref` / `sw_pos_query`  in  WIDTH_SCORE / WIDTH_POS_REF / WIDTH_POS_QUERY  core results
- `out_valid`  out  1  one-cycle result strobe
- `out_max` / `out_pos_ref` / `out_pos_query`  out  same widths  held results
- `err_char`  out  1  sticky: an invalid character was accepted
- `err_timeout`  out  1  sticky: core did not finish within TIMEOUT

## Operation
- Encoding: A/a=0, C/c=1, G/g=2, T/t=3.
  - Any other byte encodes as 0, still counts as a symbol, and sets `err_char`.
- A transfer happens when `in_valid && in_ready`. `in_ready` is a pure decode of the state: 1 only in LOAD_REF and LOAD_Q.
- LOAD_REF: write the encoded symbol to `ref_mem[wr_cnt]`. On the LEN_REF-th transfer, clear `wr_cnt` and go to LOAD_Q.
- LOAD_Q: write to `qry_mem[wr_cnt]`. On the LEN_QUERY-th transfer, go to KICK.
- KICK: `sw_rst`=1 for exactly one cycle, then go to STREAM.
- STREAM: LEN_REF cycles with `sw_valid`=1.
  - Cycle k drives `sw_ref`=`ref_mem[k]`.
  - `sw_query`=`qry_mem[k]` for k<LEN_QUERY, else 0.
  - After cycle LEN_REF-1, go to WAIT.
- WAIT: `sw_valid`=0 and the watchdog counts.
  - If `sw_finish`=1: capture `sw_*` into `out_*` and go to DONE.
  - If the watchdog reaches TIMEOUT: set `err_timeout`, load `out_*`=0 and go to DONE.
  - If both happen in the same cycle, `sw_finish` wins.
- DONE: `out_valid`=1 for one cycle, then go to LOAD_REF. `out_*` hold until the next DONE.
- `sw_finish` is ignored outside WAIT.
- `err_*` clear only on `reset`.

## Timing
- Reset values: state=LOAD_REF, all counters 0.
  - `in_ready`=1 after reset (the state is LOAD_REF).
  - `sw_rst`, `sw_valid`, `sw_ref`, `sw_query`, `out_valid`, `out_*`, `err_*` are all 0.
- `sw_*` outputs are registered, with no combinational path from `in_*`.
- Last query transfer at cycle t gives:
  - KICK (`sw_rst`=1) at t+1.
  - STREAM cycles t+2 … t+1+LEN_REF.
  - WAIT from t+2+LEN_REF.
- `sw_finish` seen high at cycle f gives `out_valid`=1 at f+1, and `in_ready`=1 again at f+2.
- No overlap: host characters are back-pressured from KICK through DONE.
- A `reset` in any state takes effect next edge: buffers are abandoned, `wr_cnt` cleared, `sw_valid` dropped immediately.
- The host may stall (`in_valid`=0) arbitrarily. No symbol is skipped or duplicated.

## Structure
- Package `sw_pkg` holds:
  - LEN_REF/LEN_QUERY defaults and the state enum (LOAD_REF, LOAD_Q, KICK, STREAM, WAIT, DONE).
  - ASCII codes and the `encode_base` function, returning symbol and invalid flag.
- Sub-module `sw_char_encoder`: registered ASCII→2-bit encoder with invalid flag. One cycle, aligned to the write strobe.
- Buffers are flop arrays `ref_mem[LEN_REF]` and `qry_mem[LEN_QUERY]`. A single `wr_cnt`/`rd_cnt` pair is sized by `$clog2(LEN_REF+1)`.

## Test plan
- **Nominal pair:** reset, then 64×"ACGT…" + 48×"ACGT…" with no stalls.
  - `sw_rst` at t+1, 64 `sw_valid` cycles, `sw_query`=0 for k≥48.
  - Model core raises finish with max=96, pos_ref=48, pos_query=48 → `out_valid` 1 cycle later with the same values.
- **Random `in_valid` stalls and lowercase input:** the streamed symbol sequence matches the encoded input exactly, and `err_char`=0.
- **Single 'N' at reference position 10:** `err_char` sets and stays 1, and `sw_ref` at k=10 is 0.
- **Core never finishes:** after 1023 WAIT cycles, `err_timeout`=1, `out_valid` pulses with `out_*`=0, and `in_ready` returns.
- **Reset mid-STREAM (k=30):** next cycle `sw_valid`=0 and state is LOAD_REF. A following full pair streams correctly.
- **Early `sw_finish` pulse during STREAM, real finish in WAIT:** the early pulse is ignored and only the WAIT values are reported.
